// File: rtl/cache_pkg.sv
// Shared cache-hierarchy constants, FSM state encoding and block address helper
// used by the L1 cache controller and the L2 miss handler.
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 21;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 5;
  localparam int BEATS    = 8;
  localparam int BEAT_W   = $clog2(BEATS);

  typedef enum logic [2:0] {
    L2MH_IDLE    = 3'd0,
    L2MH_WB_CMD  = 3'd1,
    L2MH_WB_DATA = 3'd2,
    L2MH_RD_CMD  = 3'd3,
    L2MH_RD_DATA = 3'd4,
    L2MH_ACK     = 3'd5
  } l2mh_state_t;

  function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0]   tag,
                                                   input logic [INDEX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_miss_handler_if.sv
// Signal bundle between the L2 miss handler (master), the L1 cache side and
// the L2 memory bus.
interface l2_miss_handler_if;
  import cache_pkg::*;

  logic                read_l2;
  logic                write_l2;
  logic [ADDR_W-1:0]   addr;
  logic [TAG_W-1:0]    victim_tag;
  logic [BEAT_W-1:0]   l1_rd_idx;
  logic [DATA_W-1:0]   l1_rd_data;
  logic                l1_wr_en;
  logic [BEAT_W-1:0]   l1_wr_idx;
  logic [DATA_W-1:0]   l1_wr_data;
  logic                l2_ack;
  logic                busy;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_gnt;
  logic                mem_wvalid;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_wready;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    input  read_l2, write_l2, addr, victim_tag, l1_rd_data,
           mem_gnt, mem_wready, mem_rvalid, mem_rdata,
    output l1_rd_idx, l1_wr_en, l1_wr_idx, l1_wr_data, l2_ack, busy,
           mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata
  );

  modport slave (
    output read_l2, write_l2, addr, victim_tag, l1_rd_data,
           mem_gnt, mem_wready, mem_rvalid, mem_rdata,
    input  l1_rd_idx, l1_wr_en, l1_wr_idx, l1_wr_data, l2_ack, busy,
           mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata
  );

endinterface

// File: rtl/burst_beat_counter.sv
// Beat counter for one 8-word burst; o_last flags the accepted final beat.
module burst_beat_counter
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [BEAT_W-1:0] o_cnt,
  output logic              o_last
);

  logic [BEAT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = i_inc && (r_cnt == BEAT_W'(BEATS - 1));

endmodule

// File: rtl/l2_miss_handler.sv
// Converts held refill/writeback requests into 8-beat L2 bursts.
//   state   | meaning
//   IDLE    | waiting for read_l2 / write_l2 (writeback wins)
//   WB_CMD  | write burst command until granted
//   WB_DATA | streaming victim words from L1 to L2
//   RD_CMD  | read burst command until granted
//   RD_DATA | writing returned words into L1
//   ACK     | one-cycle completion pulse
module l2_miss_handler
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  l2_miss_handler_if.master bus
);

  localparam logic [2:0] S_IDLE    = L2MH_IDLE;
  localparam logic [2:0] S_WB_CMD  = L2MH_WB_CMD;
  localparam logic [2:0] S_WB_DATA = L2MH_WB_DATA;
  localparam logic [2:0] S_RD_CMD  = L2MH_RD_CMD;
  localparam logic [2:0] S_RD_DATA = L2MH_RD_DATA;
  localparam logic [2:0] S_ACK     = L2MH_ACK;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_wr_en;
  logic [BEAT_W-1:0] r_wr_idx;
  logic [DATA_W-1:0] r_wr_data;

  logic [BEAT_W-1:0] w_cnt;
  logic              w_last;
  logic              w_clr;
  logic              w_inc;
  logic              w_wb_beat;
  logic              w_rd_beat;
  logic              w_wvalid;
  logic              w_unused_ok;

  assign w_wvalid  = (r_state == S_WB_DATA);
  assign w_wb_beat = w_wvalid && bus.mem_wready;
  assign w_rd_beat = (r_state == S_RD_DATA) && bus.mem_rvalid;
  assign w_inc     = w_wb_beat || w_rd_beat;
  assign w_clr     = ((r_state == S_WB_CMD) || (r_state == S_RD_CMD)) && bus.mem_gnt;

  // Byte offset is irrelevant: bursts are always whole blocks.
  assign w_unused_ok = &{1'b0, bus.addr[OFFSET_W-1:0]};

  burst_beat_counter u_beat_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_cnt  (w_cnt),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.write_l2) begin
            r_state    <= S_WB_CMD;
            r_mem_addr <= block_addr(bus.victim_tag, bus.addr[OFFSET_W +: INDEX_W]);
          end else if (bus.read_l2) begin
            r_state    <= S_RD_CMD;
            r_mem_addr <= block_addr(bus.addr[ADDR_W-1 -: TAG_W],
                                     bus.addr[OFFSET_W +: INDEX_W]);
          end
        end
        S_WB_CMD:  if (bus.mem_gnt) r_state <= S_WB_DATA;
        S_WB_DATA: if (w_last)      r_state <= S_ACK;
        S_RD_CMD:  if (bus.mem_gnt) r_state <= S_RD_DATA;
        S_RD_DATA: if (w_last)      r_state <= S_ACK;
        S_ACK:                      r_state <= S_IDLE;
        default:                    r_state <= S_IDLE;
      endcase
    end
  end

  // Refill words land in L1 the cycle after the beat arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_rd_beat;
      if (w_rd_beat) begin
        r_wr_idx  <= w_cnt;
        r_wr_data <= bus.mem_rdata;
      end
    end
  end

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.mem_req    = (r_state == S_WB_CMD) || (r_state == S_RD_CMD);
  assign bus.mem_we     = (r_state == S_WB_CMD);
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wvalid = w_wvalid;
  assign bus.mem_wdata  = w_wvalid ? bus.l1_rd_data : '0;
  assign bus.l1_rd_idx  = w_wvalid ? w_cnt : '0;
  assign bus.l1_wr_en   = r_wr_en;
  assign bus.l1_wr_idx  = r_wr_idx;
  assign bus.l1_wr_data = r_wr_data;
  assign bus.l2_ack     = (r_state == S_ACK);

endmodule

// File: tb/tb_l2_miss_handler.sv
// Directed bench for l2_miss_handler: refill vector table plus hand sequences
// for stalled writeback, request priority, grant delay and mid-burst reset.
module tb_l2_miss_handler;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] victim_mem [8];

  l2_miss_handler_if bus();

  l2_miss_handler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.l1_rd_data = victim_mem[bus.l1_rd_idx];

  typedef struct {
    logic        rd;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        req;
    logic        we;
    logic        busy;
    logic        wren;
    logic [2:0]  widx;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] maddr;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(logic rd, logic gnt, logic rv, logic [31:0] rdata,
                              logic req, logic we, logic busy, logic wren,
                              logic [2:0] widx, logic [31:0] wdata, logic ack,
                              logic [31:0] maddr);
    vec_t v;
    v.rd = rd; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.req = req; v.we = we; v.busy = busy; v.wren = wren;
    v.widx = widx; v.wdata = wdata; v.ack = ack; v.maddr = maddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},    32'(bus.mem_req),    32'd0);
    check({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
    check({tag, "_mem_addr"},   bus.mem_addr,        32'd0);
    check({tag, "_mem_wvalid"}, 32'(bus.mem_wvalid), 32'd0);
    check({tag, "_l1_wr_en"},   32'(bus.l1_wr_en),   32'd0);
    check({tag, "_l2_ack"},     32'(bus.l2_ack),     32'd0);
    check({tag, "_busy"},       32'(bus.busy),       32'd0);
    check({tag, "_l1_wr_idx"},  32'(bus.l1_wr_idx),  32'd0);
    check({tag, "_l1_rd_idx"},  32'(bus.l1_rd_idx),  32'd0);
    check({tag, "_l1_wr_data"}, bus.l1_wr_data,      32'd0);
  endtask

  // Eight back-to-back read beats from RD_DATA, then leave ACK with read_l2 low.
  task automatic do_refill_beats(input string tag, input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = base + 32'(i);
      step();
      check($sformatf("%s_b%0d_wren", tag, i), 32'(bus.l1_wr_en),   32'd1);
      check($sformatf("%s_b%0d_widx", tag, i), 32'(bus.l1_wr_idx),  32'(i));
      check($sformatf("%s_b%0d_wdat", tag, i), bus.l1_wr_data,      base + 32'(i));
      check($sformatf("%s_b%0d_ack",  tag, i), 32'(bus.l2_ack),     32'(i == 7));
    end
    bus.mem_rvalid = 1'b0;
    bus.read_l2    = 1'b0;
    step();
    check({tag, "_post_ack"},  32'(bus.l2_ack),   32'd0);
    check({tag, "_post_busy"}, 32'(bus.busy),     32'd0);
    check({tag, "_post_wren"}, 32'(bus.l1_wr_en), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    bit          done;
    logic [31:0] got [$];

    reset          = 1'b1;
    bus.read_l2    = 1'b0;
    bus.write_l2   = 1'b0;
    bus.addr       = '0;
    bus.victim_tag = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_wready = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    for (int i = 0; i < 8; i++) victim_mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;

    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 32'h10001fe0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 32'h10001fe0);
    for (int b = 0; b < 8; b++)
      vecs[2+b] = mk(1'b1, 1'b1, 1'b1, 32'(b + 1), 1'b0, 1'b0, 1'b1, 1'b1, 3'(b),
                     32'(b + 1), (b == 7), 32'h10001fe0);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 32'h10001fe0);

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Zero-wait refill, one table row per cycle.
    bus.addr = 32'h10001fff;
    for (int k = 0; k < 11; k++) begin
      bus.read_l2    = vecs[k].rd;
      bus.mem_gnt    = vecs[k].gnt;
      bus.mem_rvalid = vecs[k].rv;
      bus.mem_rdata  = vecs[k].rdata;
      step();
      check($sformatf("v%0d_req",  k), 32'(bus.mem_req),  32'(vecs[k].req));
      check($sformatf("v%0d_we",   k), 32'(bus.mem_we),   32'(vecs[k].we));
      check($sformatf("v%0d_busy", k), 32'(bus.busy),     32'(vecs[k].busy));
      check($sformatf("v%0d_wren", k), 32'(bus.l1_wr_en), 32'(vecs[k].wren));
      check($sformatf("v%0d_ack",  k), 32'(bus.l2_ack),   32'(vecs[k].ack));
      check($sformatf("v%0d_addr", k), bus.mem_addr,      vecs[k].maddr);
      if (vecs[k].wren) begin
        check($sformatf("v%0d_widx", k), 32'(bus.l1_wr_idx), 32'(vecs[k].widx));
        check($sformatf("v%0d_wdat", k), bus.l1_wr_data,     vecs[k].wdata);
      end
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b0;

    // Writeback with wready toggling 0/1.
    bus.write_l2   = 1'b1;
    bus.victim_tag = 21'h0abcd;
    bus.addr       = 32'h123457ff;
    bus.mem_wready = 1'b1;
    step();
    check("wb_cmd_req",    32'(bus.mem_req),    32'd1);
    check("wb_cmd_we",     32'(bus.mem_we),     32'd1);
    check("wb_cmd_addr",   bus.mem_addr,        32'h055e6fe0);
    check("wb_cmd_wvalid", 32'(bus.mem_wvalid), 32'd0);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    check("wb_data_req", 32'(bus.mem_req), 32'd0);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus.mem_wready = c[0];
      #1;
      if (bus.mem_wvalid && bus.mem_wready) got.push_back(bus.mem_wdata);
      step();
      if (bus.l2_ack) done = 1'b1;
    end
    check("wb_ack_seen",   32'(done),       32'd1);
    check("wb_word_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) check($sformatf("wb_word%0d", i), got[i], victim_mem[i]);
    end
    bus.write_l2   = 1'b0;
    bus.mem_wready = 1'b0;
    step();
    check("wb_single_ack", 32'(bus.l2_ack), 32'd0);
    check("wb_idle_busy",  32'(bus.busy),   32'd0);

    // Both requests: writeback first, one IDLE cycle, then refill.
    bus.read_l2    = 1'b1;
    bus.write_l2   = 1'b1;
    bus.victim_tag = 21'h00001;
    bus.addr       = 32'h20000040;
    step();
    check("both_first_we",   32'(bus.mem_we), 32'd1);
    check("both_first_addr", bus.mem_addr,    32'h00000840);
    bus.mem_gnt    = 1'b1;
    bus.mem_wready = 1'b1;
    cyc = 0;
    while (!bus.l2_ack && cyc < 20) begin
      step();
      cyc++;
    end
    check("both_wb_ack",    32'(bus.l2_ack), 32'd1);
    check("both_wb_cycles", 32'(cyc),        32'd9);
    bus.write_l2   = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_wready = 1'b0;
    step();
    check("both_gap_busy", 32'(bus.busy),    32'd0);
    check("both_gap_req",  32'(bus.mem_req), 32'd0);
    step();
    check("both_rd_req",  32'(bus.mem_req), 32'd1);
    check("both_rd_we",   32'(bus.mem_we),  32'd0);
    check("both_rd_addr", bus.mem_addr,     32'h20000040);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    do_refill_beats("both_rd", 32'h0000_0200);

    // Grant withheld; stray rvalid must not produce L1 writes.
    bus.read_l2    = 1'b1;
    bus.addr       = 32'h30000123;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("gd%0d_req",    c), 32'(bus.mem_req),    32'd1);
      check($sformatf("gd%0d_we",     c), 32'(bus.mem_we),     32'd0);
      check($sformatf("gd%0d_addr",   c), bus.mem_addr,        32'h30000120);
      check($sformatf("gd%0d_wren",   c), 32'(bus.l1_wr_en),   32'd0);
      check($sformatf("gd%0d_wvalid", c), 32'(bus.mem_wvalid), 32'd0);
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    check("gd_granted_req",  32'(bus.mem_req), 32'd0);
    check("gd_granted_busy", 32'(bus.busy),    32'd1);
    do_refill_beats("gd_rd", 32'h0000_0300);

    // Reset after beat 3 of a refill, then a clean refill from beat 0.
    bus.read_l2 = 1'b1;
    bus.addr    = 32'h40000000;
    bus.mem_gnt = 1'b1;
    step();
    step();
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h0000_0400 + 32'(i);
      step();
    end
    check("mid_pre_widx", 32'(bus.l1_wr_idx), 32'd3);
    bus.mem_rvalid = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("mid_rst");
    bus.read_l2 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("mid_rst%0d_ack",  c), 32'(bus.l2_ack), 32'd0);
      check($sformatf("mid_rst%0d_busy", c), 32'(bus.busy),   32'd0);
    end
    reset       = 1'b0;
    bus.read_l2 = 1'b1;
    bus.addr    = 32'h40000020;
    step();
    check("post_rst_req",  32'(bus.mem_req), 32'd1);
    check("post_rst_addr", bus.mem_addr,     32'h40000020);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    do_refill_beats("post_rst", 32'h0000_0500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
